lzss_match_search: RTL and testbench
====================================

LZSS_MATCH_SEARCH -- requirements
Module: lzss_match_search

Interface
REQ-001 The block SHALL have parameter pDictDepth, default 16, meaning number of dictionary (history) bytes.
REQ-002 The block SHALL have parameter pLookDepth, default 8, meaning number of lookahead bytes and the maximum match length.
REQ-003 The block SHALL have parameter pMinMatch, default 2, meaning the shortest length emitted as a match.
REQ-004 The block SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous and active-high.
REQ-005 The block SHALL have ports: i_valid  in  1  window contents valid; i_dict  in  pDictDepth*8  history, byte i at [i*8+:8], index pDictDepth-1 newest; i_dict_cnt  in  clog2(pDictDepth+1)  valid history bytes, counted from the newest.
REQ-006 The block SHALL have ports: i_look  in  pLookDepth*8  lookahead, byte 0 at [7:0] is the next byte to encode; i_look_cnt  in  clog2(pLookDepth+1)  valid lookahead bytes.
REQ-007 The block SHALL have ports: o_shift  out  1  one-byte shift strobe to the window buffers; o_busy  out  1  high in every state except IDLE.
REQ-008 The block SHALL have ports: o_tok_valid  out  1; i_tok_ready  in  1; o_tok_is_match  out  1; o_tok_lit  out  8; o_tok_offset  out  clog2(pDictDepth+1); o_tok_length  out  clog2(pLookDepth+1).

Function
REQ-009 The FSM SHALL have four states: IDLE, SEARCH, EMIT, SHIFT.
REQ-010 IDLE: when i_valid=1 and i_look_cnt!=0, the FSM SHALL go to SEARCH with candidate offset 1; when i_dict_cnt=0, it SHALL go directly to EMIT as a literal.
REQ-011 IDLE: when i_look_cnt=0, the FSM SHALL remain in IDLE and emit nothing.
REQ-012 SEARCH SHALL evaluate one offset d per cycle, d=1..i_dict_cnt; the candidate length is the count of leading k with i_look[k]==i_dict[pDictDepth-d+k], capped at min(d, i_look_cnt).
REQ-013 Best match SHALL be replaced only on strictly greater length, so ties keep the smallest offset.
REQ-014 After the last offset, a best length below pMinMatch SHALL yield a literal: is_match=0, lit=i_look[7:0], length=1, offset=0.
REQ-015 EMIT SHALL hold o_tok_valid=1 and all token fields stable until i_tok_ready=1; the handshake completes on the cycle where both are high.
REQ-016 On handshake, the FSM SHALL enter SHIFT and assert o_shift for exactly o_tok_length consecutive cycles, then return to IDLE.
REQ-017 o_shift SHALL be 0 outside SHIFT; i_dict, i_look and the counts SHALL be held stable by upstream while o_busy=1.
REQ-018 Latency: with i_valid sampled in IDLE at cycle 0, o_tok_valid SHALL rise at cycle (number of offsets searched)+1.

Reset
REQ-019 With rst=1 at a clock edge, the FSM SHALL enter IDLE and clear the best match, the offset counter and the shift counter.
REQ-020 During and after reset, o_shift, o_busy, o_tok_valid, o_tok_is_match, o_tok_lit, o_tok_offset and o_tok_length SHALL all be 0.
REQ-021 Reset asserted in any state SHALL abort the operation with no further token and no further o_shift.

Configuration
REQ-022 With LZSS_MATCH_EARLY_EXIT_EN defined, SEARCH SHALL end on the cycle a candidate reaches length min(i_look_cnt, pLookDepth).
REQ-023 Without LZSS_MATCH_EARLY_EXIT_EN, SEARCH SHALL always scan all i_dict_cnt offsets; tokens SHALL be identical in both builds, and only latency SHALL differ.

Structure
REQ-024 The shared package lzss_pkg SHALL hold the FSM state encoding, the token field width constants and a clog2 function.
REQ-025 The byte compare and leading-equal count SHALL be a combinational sub-module named lzss_match_len.

Verification (pDictDepth=16, pLookDepth=8, pMinMatch=2)
REQ-026 Set i_dict_cnt=0, i_look="A" (cnt 1) and i_tok_ready=1 -> literal 0x41 at cycle 1, then one o_shift pulse, then IDLE.
REQ-027 Set dict bytes 13..15="ABC" (cnt 3) and look="ABCX" (cnt 4) -> match with offset 3, length 3, then 3 o_shift pulses.
REQ-028 Set "AB" at dict bytes 10..11 and 14..15 (cnt 16) and look="ABQ" -> match with offset 2, length 2 (tie resolved to the smallest offset).
REQ-029 Hold i_tok_ready=0 for 5 cycles in EMIT -> o_tok_valid and the token stay stable, and o_shift stays 0 throughout.
REQ-030 Set dict bytes 12..15="WXYZ" (cnt 16) and look="WXYZ" (cnt 4) -> o_tok_valid at cycle 5 with the macro defined, at cycle 17 without it.
REQ-031 Assert rst during SEARCH and during SHIFT -> all outputs 0 on the next cycle, the FSM in IDLE, and no residual o_shift.

Source files
------------

// File: rtl/lzss_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lzss_pkg
//  Description : Shared definitions for the LZSS match-search slice: FSM state
//                encoding, token field width constants and a constant clog2.
//  Revision    : 1.0 - initial release
// ============================================================================
package lzss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_EMIT   = 2'd2,
        ST_SHIFT  = 2'd3
    } state_t;

    // Width of the literal field and of one window byte.
    localparam int c_LIT_W  = 8;
    localparam int c_BYTE_W = 8;

    // Ceiling log2, usable in constant expressions (port widths).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Token offset field must hold 0..dict_depth; length field 0..look_depth.
    function automatic int tok_off_w(input int dict_depth);
        return clog2(dict_depth + 1);
    endfunction

    function automatic int tok_len_w(input int look_depth);
        return clog2(look_depth + 1);
    endfunction

endpackage : lzss_pkg
`default_nettype wire

// File: rtl/lzss_match_len.sv
`default_nettype none
// ============================================================================
//  Module      : lzss_match_len
//  Description : Combinational match length for one candidate offset. Counts
//                the leading lookahead bytes equal to the history starting
//                i_offset bytes back, capped at min(i_offset, i_look_cnt).
//  Ports       : i_dict     - history window, newest byte at the top
//                i_look     - lookahead window, byte 0 at [7:0]
//                i_offset   - candidate offset (1..pDictDepth)
//                i_look_cnt - valid lookahead bytes
//                o_len      - leading-equal count
//  Revision    : 1.0 - initial release
// ============================================================================
module lzss_match_len
    import lzss_pkg::*;
#(
    parameter int pDictDepth = 16,
    parameter int pLookDepth = 8
) (
    input  logic [pDictDepth*c_BYTE_W-1:0]   i_dict,
    input  logic [pLookDepth*c_BYTE_W-1:0]   i_look,
    input  logic [tok_off_w(pDictDepth)-1:0] i_offset,
    input  logic [tok_len_w(pLookDepth)-1:0] i_look_cnt,
    output logic [tok_len_w(pLookDepth)-1:0] o_len
);

    localparam int c_LW = tok_len_w(pLookDepth);

    // Align history so that byte k of w_win is dict[pDictDepth-offset+k].
    // Bytes past the newest one shift in as zero; they are masked by the
    // k < offset cap below, so their value never matters.
    logic [pLookDepth*c_BYTE_W-1:0] w_win;
    logic [pLookDepth-1:0]          w_eq;
    logic                           w_run;

    assign w_win = (pLookDepth*c_BYTE_W)'(i_dict >> (c_BYTE_W * (pDictDepth - int'(i_offset))));

    for (genvar k = 0; k < pLookDepth; k++) begin : g_byte
        assign w_eq[k] = (k < int'(i_offset)) && (k < int'(i_look_cnt)) &&
                         (w_win[k*c_BYTE_W +: c_BYTE_W] == i_look[k*c_BYTE_W +: c_BYTE_W]);
    end

    // Leading-ones count of w_eq.
    always_comb begin
        o_len = '0;
        w_run = 1'b1;
        for (int k = 0; k < pLookDepth; k++) begin
            w_run = w_run & w_eq[k];
            if (w_run) o_len = o_len + c_LW'(1);
        end
    end

endmodule : lzss_match_len
`default_nettype wire

// File: rtl/lzss_match_search.sv
`default_nettype none
// ============================================================================
//  Module      : lzss_match_search
//  Description : LZSS longest-match search, one dictionary offset per cycle.
//                Emits a literal or (offset, length) token over a valid/ready
//                handshake, then pulses o_shift once per consumed byte.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                i_valid              - window contents valid (sampled in IDLE)
//                i_dict, i_dict_cnt   - history window and valid byte count
//                i_look, i_look_cnt   - lookahead window and valid byte count
//                o_shift              - one-byte shift strobe to window buffers
//                o_busy               - high whenever not IDLE
//                o_tok_*, i_tok_ready - token output handshake
//  Config      : LZSS_MATCH_EARLY_EXIT_EN - stop searching as soon as a
//                candidate covers the whole lookahead (latency only; tokens
//                are unchanged).
//  Revision    : 1.0 - initial release
// ============================================================================
module lzss_match_search
    import lzss_pkg::*;
#(
    parameter int pDictDepth = 16,
    parameter int pLookDepth = 8,
    parameter int pMinMatch  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    input  logic [pDictDepth*c_BYTE_W-1:0]   i_dict,
    input  logic [tok_off_w(pDictDepth)-1:0] i_dict_cnt,
    input  logic [pLookDepth*c_BYTE_W-1:0]   i_look,
    input  logic [tok_len_w(pLookDepth)-1:0] i_look_cnt,
    output logic                             o_shift,
    output logic                             o_busy,
    output logic                             o_tok_valid,
    input  logic                             i_tok_ready,
    output logic                             o_tok_is_match,
    output logic [c_LIT_W-1:0]               o_tok_lit,
    output logic [tok_off_w(pDictDepth)-1:0] o_tok_offset,
    output logic [tok_len_w(pLookDepth)-1:0] o_tok_length
);

    localparam int c_DW = tok_off_w(pDictDepth);
    localparam int c_LW = tok_len_w(pLookDepth);

    state_t          r_state;
    logic [c_DW-1:0] r_off;
    logic [c_DW-1:0] r_best_off;
    logic [c_LW-1:0] r_best_len;
    logic [c_LW-1:0] r_shift_cnt;

    logic [c_LW-1:0] w_len;
    logic            w_better;
    logic [c_LW-1:0] w_fin_len;
    logic [c_DW-1:0] w_fin_off;
    logic [c_LW-1:0] w_target;
    logic            w_done;
    logic            w_is_lit;

    lzss_match_len #(
        .pDictDepth (pDictDepth),
        .pLookDepth (pLookDepth)
    ) u_match_len (
        .i_dict     (i_dict),
        .i_look     (i_look),
        .i_offset   (r_off),
        .i_look_cnt (i_look_cnt),
        .o_len      (w_len)
    );

    // Strictly-greater replacement keeps the smallest offset on ties; the
    // final decision folds in the candidate evaluated this cycle.
    always_comb begin
        w_better  = (w_len > r_best_len);
        w_fin_len = w_better ? w_len : r_best_len;
        w_fin_off = w_better ? r_off : r_best_off;
        w_target  = (int'(i_look_cnt) > pLookDepth) ? c_LW'(pLookDepth) : i_look_cnt;
`ifdef LZSS_MATCH_EARLY_EXIT_EN
        // A full-length candidate can never be beaten later, so stopping
        // here leaves the token unchanged.
        w_done    = (r_off >= i_dict_cnt) || (w_len == w_target);
`else
        w_done    = (r_off >= i_dict_cnt);
`endif
        w_is_lit  = (int'(w_fin_len) < pMinMatch);
    end

    assign o_busy  = (r_state != ST_IDLE);
    assign o_shift = (r_state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_off          <= '0;
            r_best_off     <= '0;
            r_best_len     <= '0;
            r_shift_cnt    <= '0;
            o_tok_valid    <= 1'b0;
            o_tok_is_match <= 1'b0;
            o_tok_lit      <= '0;
            o_tok_offset   <= '0;
            o_tok_length   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid && (i_look_cnt != '0)) begin
                        r_best_len <= '0;
                        r_best_off <= '0;
                        if (i_dict_cnt == '0) begin
                            // Empty history: nothing to search, literal now.
                            o_tok_valid    <= 1'b1;
                            o_tok_is_match <= 1'b0;
                            o_tok_lit      <= i_look[c_LIT_W-1:0];
                            o_tok_offset   <= '0;
                            o_tok_length   <= c_LW'(1);
                            r_state        <= ST_EMIT;
                        end else begin
                            r_off   <= c_DW'(1);
                            r_state <= ST_SEARCH;
                        end
                    end
                end

                ST_SEARCH: begin
                    if (w_better) begin
                        r_best_len <= w_len;
                        r_best_off <= r_off;
                    end
                    if (w_done) begin
                        o_tok_valid <= 1'b1;
                        if (w_is_lit) begin
                            o_tok_is_match <= 1'b0;
                            o_tok_lit      <= i_look[c_LIT_W-1:0];
                            o_tok_offset   <= '0;
                            o_tok_length   <= c_LW'(1);
                        end else begin
                            o_tok_is_match <= 1'b1;
                            o_tok_lit      <= '0;
                            o_tok_offset   <= w_fin_off;
                            o_tok_length   <= w_fin_len;
                        end
                        r_state <= ST_EMIT;
                    end else begin
                        r_off <= r_off + c_DW'(1);
                    end
                end

                ST_EMIT: begin
                    if (i_tok_ready) begin
                        r_shift_cnt    <= o_tok_length;
                        o_tok_valid    <= 1'b0;
                        o_tok_is_match <= 1'b0;
                        o_tok_lit      <= '0;
                        o_tok_offset   <= '0;
                        o_tok_length   <= '0;
                        r_state        <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // One o_shift cycle per consumed byte; the last one
                    // returns to IDLE.
                    if (r_shift_cnt <= c_LW'(1)) begin
                        r_shift_cnt <= '0;
                        r_off       <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_shift_cnt <= r_shift_cnt - c_LW'(1);
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : lzss_match_search
`default_nettype wire

// File: tb/tb_lzss_match_search.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lzss_match_search
//  Description : Directed self-checking bench for lzss_match_search
//                (pDictDepth=16, pLookDepth=8, pMinMatch=2). Expected
//                latencies follow LZSS_MATCH_EARLY_EXIT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lzss_match_search;

    localparam int DICT = 16;
    localparam int LOOK = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic [DICT*8-1:0] i_dict;
    logic [4:0]        i_dict_cnt;
    logic [LOOK*8-1:0] i_look;
    logic [3:0]        i_look_cnt;
    logic              o_shift;
    logic              o_busy;
    logic              o_tok_valid;
    logic              i_tok_ready;
    logic              o_tok_is_match;
    logic [7:0]        o_tok_lit;
    logic [4:0]        o_tok_offset;
    logic [3:0]        o_tok_length;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lzss_match_search #(
        .pDictDepth (DICT),
        .pLookDepth (LOOK),
        .pMinMatch  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .i_dict         (i_dict),
        .i_dict_cnt     (i_dict_cnt),
        .i_look         (i_look),
        .i_look_cnt     (i_look_cnt),
        .o_shift        (o_shift),
        .o_busy         (o_busy),
        .o_tok_valid    (o_tok_valid),
        .i_tok_ready    (i_tok_ready),
        .o_tok_is_match (o_tok_is_match),
        .o_tok_lit      (o_tok_lit),
        .o_tok_offset   (o_tok_offset),
        .o_tok_length   (o_tok_length)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {11'd0, o_shift, o_busy, o_tok_valid, o_tok_is_match,
                o_tok_lit, o_tok_offset, o_tok_length};
    endfunction

    task automatic clear_window();
        i_dict     = {DICT{8'h2E}};
        i_look     = {LOOK{8'h2E}};
        i_dict_cnt = 5'd0;
        i_look_cnt = 4'd0;
    endtask

    // Pulse i_valid for one sampled edge, then wait for the token; cycle 1 is
    // the first observation after the sampling edge.
    task automatic wait_token(input string tag, input int exp_cyc);
        int cyc;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        cyc = 1;
        while (o_tok_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, " tok_valid"}, {31'd0, o_tok_valid}, 32'd1);
        check({tag, " latency"}, cyc, exp_cyc);
    endtask

    task automatic check_tok(input string tag, input logic m, input logic [7:0] lit,
                             input logic [4:0] off, input logic [3:0] len, input bit do_lit);
        check({tag, " is_match"}, {31'd0, o_tok_is_match}, {31'd0, m});
        if (do_lit) check({tag, " lit"}, {24'd0, o_tok_lit}, {24'd0, lit});
        check({tag, " offset"}, {27'd0, o_tok_offset}, {27'd0, off});
        check({tag, " length"}, {28'd0, o_tok_length}, {28'd0, len});
    endtask

    // Called right after the handshake edge: count consecutive o_shift cycles.
    task automatic count_shifts(input string tag, input int exp_n);
        int n;
        n = 0;
        while (o_shift === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check({tag, " shifts"}, n, exp_n);
        check({tag, " idle busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, " idle tok_valid"}, {31'd0, o_tok_valid}, 32'd0);
    endtask

    logic seen;

    initial begin
        rst         = 1'b1;
        i_valid     = 1'b0;
        i_tok_ready = 1'b0;
        clear_window();

        // Reset state
        tick(); tick();
        check("reset outputs", all_outs(), 32'd0);
        rst = 1'b0;
        tick();
        check("post-reset outputs", all_outs(), 32'd0);

        // Empty lookahead: stays IDLE
        i_dict_cnt = 5'd3;
        i_valid    = 1'b1;
        tick();
        i_valid = 1'b0;
        check("look_cnt0 busy", {31'd0, o_busy}, 32'd0);
        check("look_cnt0 tok_valid", {31'd0, o_tok_valid}, 32'd0);
        tick();

        // Empty history: immediate literal 'A'
        clear_window();
        i_look[7:0] = "A";
        i_look_cnt  = 4'd1;
        i_tok_ready = 1'b1;
        wait_token("lit0", 1);
        check_tok("lit0", 1'b0, 8'h41, 5'd0, 4'd1, 1'b1);
        tick();
        count_shifts("lit0", 1);

        // "ABC" history, "ABCX" lookahead: match offset 3 length 3
        clear_window();
        i_dict[13*8 +: 8] = "A";
        i_dict[14*8 +: 8] = "B";
        i_dict[15*8 +: 8] = "C";
        i_dict_cnt = 5'd3;
        i_look[0*8 +: 8] = "A";
        i_look[1*8 +: 8] = "B";
        i_look[2*8 +: 8] = "C";
        i_look[3*8 +: 8] = "X";
        i_look_cnt = 4'd4;
        wait_token("abc", 4);
        check_tok("abc", 1'b1, 8'h00, 5'd3, 4'd3, 1'b0);
        tick();
        count_shifts("abc", 3);

        // Best length 1 is below the minimum: literal 'A'
        i_look[1*8 +: 8] = "Q";
        i_look_cnt = 4'd2;
        wait_token("minlen", 4);
        check_tok("minlen", 1'b0, 8'h41, 5'd0, 4'd1, 1'b1);
        tick();
        count_shifts("minlen", 1);

        // Tie between offsets 2 and 6 resolves to 2
        clear_window();
        i_dict[10*8 +: 8] = "A";
        i_dict[11*8 +: 8] = "B";
        i_dict[14*8 +: 8] = "A";
        i_dict[15*8 +: 8] = "B";
        i_dict_cnt = 5'd16;
        i_look[0*8 +: 8] = "A";
        i_look[1*8 +: 8] = "B";
        i_look[2*8 +: 8] = "Q";
        i_look_cnt = 4'd3;
        wait_token("tie", 17);
        check_tok("tie", 1'b1, 8'h00, 5'd2, 4'd2, 1'b0);
        tick();
        count_shifts("tie", 2);

        // Backpressure: token held stable, no shift while ready is low
        clear_window();
        i_dict[13*8 +: 8] = "A";
        i_dict[14*8 +: 8] = "B";
        i_dict[15*8 +: 8] = "C";
        i_dict_cnt = 5'd3;
        i_look[0*8 +: 8] = "A";
        i_look[1*8 +: 8] = "B";
        i_look[2*8 +: 8] = "C";
        i_look[3*8 +: 8] = "X";
        i_look_cnt  = 4'd4;
        i_tok_ready = 1'b0;
        wait_token("stall", 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall hold", {26'd0, o_tok_valid, o_shift, o_tok_is_match, o_tok_offset[2:0]},
                  {26'd0, 1'b1, 1'b0, 1'b1, 3'd3});
            check("stall length", {28'd0, o_tok_length}, 32'd3);
        end
        i_tok_ready = 1'b1;
        tick();
        count_shifts("stall", 3);

        // Full-lookahead match "WXYZ": latency depends on early exit
        clear_window();
        i_dict[12*8 +: 8] = "W";
        i_dict[13*8 +: 8] = "X";
        i_dict[14*8 +: 8] = "Y";
        i_dict[15*8 +: 8] = "Z";
        i_dict_cnt = 5'd16;
        i_look[0*8 +: 8] = "W";
        i_look[1*8 +: 8] = "X";
        i_look[2*8 +: 8] = "Y";
        i_look[3*8 +: 8] = "Z";
        i_look_cnt = 4'd4;
`ifdef LZSS_MATCH_EARLY_EXIT_EN
        wait_token("wxyz", 5);
`else
        wait_token("wxyz", 17);
`endif
        check_tok("wxyz", 1'b1, 8'h00, 5'd4, 4'd4, 1'b0);
        tick();
        count_shifts("wxyz", 4);

        // Reset during SEARCH
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick(); tick();
        check("rst search busy before", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("rst search outputs", all_outs(), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_tok_valid !== 1'b0 || o_shift !== 1'b0 || o_busy !== 1'b0) seen = 1'b1;
        end
        check("rst search residual", {31'd0, seen}, 32'd0);

        // Reset during SHIFT
`ifdef LZSS_MATCH_EARLY_EXIT_EN
        wait_token("rst shift", 5);
`else
        wait_token("rst shift", 17);
`endif
        tick();
        check("rst shift active", {31'd0, o_shift}, 32'd1);
        rst = 1'b1;
        tick();
        check("rst shift outputs", all_outs(), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_tok_valid !== 1'b0 || o_shift !== 1'b0 || o_busy !== 1'b0) seen = 1'b1;
        end
        check("rst shift residual", {31'd0, seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lzss_match_search
`default_nettype wire
